// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data-memory port for loads/stores, aligns and extends
// load data, and emits a one-cycle result pulse. Define MEM_MISALIGN_CHECK_EN to fault misaligned accesses.
module mem_access_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                M_valid_i,
  output logic                M_ready_o,
  input  logic                M_op_load_i,
  input  logic                M_op_store_i,
  input  logic [2:0]          M_funct3_i,
  input  logic [DATA_W-1:0]   M_valE_i,
  input  logic [DATA_W-1:0]   M_valB_i,
  input  logic                M_flush_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_wstrb_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i,
  input  logic                dmem_err_i,
  output logic                m_valid_o,
  output logic [DATA_W-1:0]   m_valE_o,
  output logic [DATA_W-1:0]   m_valM_o,
  output logic                m_fault_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
  state_t state, state_next;

  logic              is_load, is_store;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] vale, store_data;
  logic [ADDR_W-1:0] addr;
  logic [OFF_W-1:0]  off;
  logic              accept, done, done_fault, done_load, misaligned;
  logic [DATA_W-1:0] shifted, load_ext;

  assign addr = vale[ADDR_W-1:0];
  assign off  = addr[OFF_W-1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  logic [OFF_W-1:0] in_off;
  logic             off_bad;
  assign in_off = M_valE_i[OFF_W-1:0];
  always_comb begin
    case (M_funct3_i[1:0])
      2'b00:   off_bad = 1'b0;
      2'b01:   off_bad = in_off[0];
      2'b10:   off_bad = |in_off[1:0];
      default: off_bad = |in_off;
    endcase
  end
  assign misaligned = (M_op_load_i | M_op_store_i) & off_bad;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    done_fault = 1'b0;
    done_load  = 1'b0;
    case (state)
      IDLE: if (M_valid_i && !M_flush_i) begin
        accept = 1'b1;
        if ((M_op_load_i || M_op_store_i) && !misaligned) state_next = REQ;
        else begin
          done       = 1'b1;
          done_fault = misaligned;
        end
      end
      REQ: if (dmem_gnt_i) begin
        // a granted store is committed on the bus even when flushed; only its pulse is dropped
        if (is_store) begin
          state_next = IDLE;
          done       = !M_flush_i;
          done_fault = dmem_err_i;
        end else state_next = M_flush_i ? DRAIN : RESP;
      end else if (M_flush_i) state_next = IDLE;
      RESP: if (dmem_rvalid_i) begin
        state_next = IDLE;
        done       = !M_flush_i;
        done_fault = dmem_err_i;
        done_load  = 1'b1;
      end else if (M_flush_i) state_next = DRAIN;
      DRAIN: if (dmem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      m_valid_o <= 1'b0;
      m_valE_o  <= '0;
      m_valM_o  <= '0;
      m_fault_o <= 1'b0;
    end else begin
      state     <= state_next;
      m_valid_o <= done;
      if (done) begin
        m_valE_o  <= accept ? M_valE_i : vale;
        m_valM_o  <= done_load ? load_ext : '0;
        m_fault_o <= done_fault;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      is_load    <= M_op_load_i;
      is_store   <= M_op_store_i;
      funct3     <= M_funct3_i;
      vale       <= M_valE_i;
      store_data <= M_valB_i;
    end
  end

  assign M_ready_o    = (state == IDLE);
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = (state == REQ) & is_store;
  assign dmem_addr_o  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wdata_o = store_data << {off, 3'b000};

  // lanes shifted past the top byte fall off, which is how misaligned stores behave unchecked
  always_comb begin
    case (funct3[1:0])
      2'b00:   dmem_wstrb_o = {{(NB-1){1'b0}}, 1'b1} << off;
      2'b01:   dmem_wstrb_o = {{(NB-2){1'b0}}, 2'b11} << off;
      2'b10:   dmem_wstrb_o = {{(NB-4){1'b0}}, 4'hF} << off;
      default: dmem_wstrb_o = {NB{1'b1}};
    endcase
  end

  assign shifted = dmem_rdata_i >> {off, 3'b000};
  always_comb begin
    case (funct3)
      3'b000:  load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      3'b110:  load_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // is_load is implied by the RESP path; kept so the captured op is visible for debug
  logic unused_ok;
  assign unused_ok = is_load;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage plus hand-written multi-cycle sequences.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid_i, M_ready_o, M_op_load_i, M_op_store_i, M_flush_i;
  logic [2:0]  M_funct3_i;
  logic [63:0] M_valE_i, M_valB_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [63:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [7:0]  dmem_wstrb_o;
  logic        m_valid_o, m_fault_o;
  logic [63:0] m_valE_o, m_valM_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .M_valid_i(M_valid_i), .M_ready_o(M_ready_o),
    .M_op_load_i(M_op_load_i), .M_op_store_i(M_op_store_i),
    .M_funct3_i(M_funct3_i), .M_valE_i(M_valE_i), .M_valB_i(M_valB_i),
    .M_flush_i(M_flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i),
    .m_valid_o(m_valid_o), .m_valE_o(m_valE_o), .m_valM_o(m_valM_o), .m_fault_o(m_fault_o)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [63:0] vale, valb, rdata;
    logic        err, mis;
    logic [7:0]  strb;
    logic [63:0] wdata, valm;
    logic        fault;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] vale, input logic [63:0] valb);
    M_valid_i = 1'b1; M_op_load_i = ld; M_op_store_i = st;
    M_funct3_i = f3; M_valE_i = vale; M_valB_i = valb;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    logic skip;
    skip = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    skip = v.mis;
`endif
    @(negedge clk);
    present(v.ld, v.st, v.f3, v.vale, v.valb);
    @(negedge clk);
    M_valid_i = 1'b0;
    if (!v.ld && !v.st) begin
      check($sformatf("v%0d pulse", i), m_valid_o, 1);
      check($sformatf("v%0d valE", i), m_valE_o, v.vale);
      check($sformatf("v%0d valM", i), m_valM_o, 0);
      check($sformatf("v%0d fault", i), m_fault_o, 0);
    end else if (skip) begin
      check($sformatf("v%0d mis req", i), dmem_req_o, 0);
      check($sformatf("v%0d mis pulse", i), m_valid_o, 1);
      check($sformatf("v%0d mis fault", i), m_fault_o, 1);
      check($sformatf("v%0d mis valM", i), m_valM_o, 0);
    end else begin
      check($sformatf("v%0d req", i), dmem_req_o, 1);
      check($sformatf("v%0d we", i), dmem_we_o, v.st);
      check($sformatf("v%0d addr", i), dmem_addr_o, v.vale & ~64'h7);
      check($sformatf("v%0d ready", i), M_ready_o, 0);
      if (v.st) begin
        check($sformatf("v%0d wstrb", i), dmem_wstrb_o, v.strb);
        check($sformatf("v%0d wdata", i), dmem_wdata_o, v.wdata);
      end
      dmem_gnt_i = 1'b1; dmem_err_i = v.st ? v.err : 1'b0;
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_err_i = 1'b0;
      if (v.st) begin
        check($sformatf("v%0d st pulse", i), m_valid_o, 1);
        check($sformatf("v%0d st fault", i), m_fault_o, v.err);
        check($sformatf("v%0d st valM", i), m_valM_o, 0);
        check($sformatf("v%0d st valE", i), m_valE_o, v.vale);
      end else begin
        check($sformatf("v%0d resp nopulse", i), m_valid_o, 0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata; dmem_err_i = v.err;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
        check($sformatf("v%0d ld pulse", i), m_valid_o, 1);
        check($sformatf("v%0d ld valM", i), m_valM_o, v.valm);
        check($sformatf("v%0d ld fault", i), m_fault_o, v.err);
        check($sformatf("v%0d ld valE", i), m_valE_o, v.vale);
      end
    end
    @(negedge clk);
    check($sformatf("v%0d single pulse", i), m_valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          ld    st    f3      vale                    valb                    rdata                   err   mis   strb   wdata                   valm                    fault
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 64'h1234,               64'h0,                  64'h0,                  1'b0, 1'b0, 8'h00, 64'h0,                  64'h0,                  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 64'h1003,               64'h0,                  64'h0000_0000_8000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 64'h1003,               64'h0,                  64'h0000_0000_8000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'h80,                 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 64'h2006,               64'hBEEF,               64'h0,                  1'b0, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 64'h1004,               64'h0,                  64'h8765_4321_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b110, 64'h1004,               64'h0,                  64'h8765_4321_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_8765_4321, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 64'h1002,               64'h0,                  64'h0000_0000_8001_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 64'h1006,               64'h0,                  64'hF00D_0000_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hF00D,               1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 64'h3000,               64'h0,                  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b111, 64'h3008,               64'h0,                  64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hFEDC_BA98_7654_3210, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b011, 64'h4000,               64'h1122_3344_5566_7788, 64'h0,                 1'b0, 1'b0, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b010, 64'h4004,               64'hDEAD_BEEF,          64'h0,                  1'b0, 1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0,                  1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 64'h4001,               64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                 1'b0, 1'b0, 8'h02, 64'hFFFF_FFFF_FFFF_AB00, 64'h0,                  1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 64'h5000,               64'hAB,                 64'h0,                  1'b1, 1'b0, 8'h01, 64'hAB,                  64'h0,                  1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 64'h5000,               64'h0,                  64'h7F,                 1'b1, 1'b0, 8'h00, 64'h0,                   64'h7F,                 1'b1};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 64'h1002,               64'h0,                  64'h0000_8765_4321_0000, 1'b0, 1'b1, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'b010, 64'h4006,               64'hCAFE_BABE,          64'h0,                  1'b0, 1'b1, 8'hC0, 64'hBABE_0000_0000_0000, 64'h0,                  1'b0};
    vecs[17] = '{1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 64'h0,                  1'b0, 1'b0, 8'h00, 64'h0,                   64'h0,                  1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'b000, 64'h2007,               64'h0,                  64'hFF00_0000_0000_0000, 1'b0, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    // reset dominates a presented load
    rst = 1'b1; M_flush_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = '0;
    present(1'b1, 1'b0, 3'b011, 64'h8000, 64'h0);
    repeat (3) @(negedge clk);
    check("rst req", dmem_req_o, 0);
    check("rst valid", m_valid_o, 0);
    check("rst valE", m_valE_o, 0);
    check("rst valM", m_valM_o, 0);
    check("rst fault", m_fault_o, 0);
    check("rst ready", M_ready_o, 1);
    M_valid_i = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // load with grant delayed 3 cycles and rvalid 2 cycles after that
    @(negedge clk);
    present(1'b1, 1'b0, 3'b010, 64'h1004, 64'h0);
    @(negedge clk);
    M_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("slow req", dmem_req_o, 1);
      check("slow addr", dmem_addr_o, 64'h1000);
      check("slow ready", M_ready_o, 0);
      check("slow nopulse", m_valid_o, 0);
      @(negedge clk);
    end
    check("slow req at gnt", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("slow resp req", dmem_req_o, 0);
      check("slow resp ready", M_ready_o, 0);
      check("slow resp nopulse", m_valid_o, 0);
      @(negedge clk);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h8765_4321_0000_0000;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("slow pulse", m_valid_o, 1);
    check("slow valM", m_valM_o, 64'hFFFF_FFFF_8765_4321);
    check("slow ready back", M_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("slow no repeat", m_valid_o, 0);
    end

    // flush a load in RESP, with an addi waiting upstream
    @(negedge clk);
    present(1'b1, 1'b0, 3'b011, 64'h6000, 64'h0);
    @(negedge clk);
    M_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0; M_flush_i = 1'b1;
    @(negedge clk);
    M_flush_i = 1'b0;
    present(1'b0, 1'b0, 3'b000, 64'h5555, 64'h0);
    check("drain ready", M_ready_o, 0);
    check("drain nopulse", m_valid_o, 0);
    @(negedge clk);
    check("drain wait ready", M_ready_o, 0);
    check("drain wait nopulse", m_valid_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("drain discard", m_valid_o, 0);
    check("drain idle", M_ready_o, 1);
    @(negedge clk);
    M_valid_i = 1'b0;
    check("addi after drain pulse", m_valid_o, 1);
    check("addi after drain valE", m_valE_o, 64'h5555);
    check("addi after drain valM", m_valM_o, 0);
    @(negedge clk);
    check("addi after drain single", m_valid_o, 0);

    // flush in REQ before grant
    present(1'b1, 1'b0, 3'b000, 64'h7000, 64'h0);
    @(negedge clk);
    M_valid_i = 1'b0;
    check("flreq req", dmem_req_o, 1);
    M_flush_i = 1'b1;
    @(negedge clk);
    M_flush_i = 1'b0;
    check("flreq dropped", dmem_req_o, 0);
    check("flreq ready", M_ready_o, 1);
    check("flreq nopulse", m_valid_o, 0);
    @(negedge clk);
    check("flreq nopulse2", m_valid_o, 0);

    // flushed store on its grant cycle: bus sees it, no pulse
    present(1'b0, 1'b1, 3'b011, 64'h7100, 64'h99);
    @(negedge clk);
    M_valid_i = 1'b0;
    check("flst req", dmem_req_o, 1);
    check("flst we", dmem_we_o, 1);
    dmem_gnt_i = 1'b1; M_flush_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0; M_flush_i = 1'b0;
    check("flst nopulse", m_valid_o, 0);
    check("flst ready", M_ready_o, 1);

    // flush in IDLE kills the presented op
    present(1'b0, 1'b0, 3'b000, 64'h4242, 64'h0);
    M_flush_i = 1'b1;
    @(negedge clk);
    M_valid_i = 1'b0; M_flush_i = 1'b0;
    check("flidle nopulse", m_valid_o, 0);
    check("flidle ready", M_ready_o, 1);

    // reset mid-transaction abandons it
    present(1'b1, 1'b0, 3'b011, 64'h7200, 64'h0);
    @(negedge clk);
    M_valid_i = 1'b0;
    check("rstmid req", dmem_req_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid req low", dmem_req_o, 0);
    check("rstmid ready", M_ready_o, 1);
    check("rstmid nopulse", m_valid_o, 0);
    @(negedge clk);
    check("rstmid nopulse2", m_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
